// File: rtl/tcp_rx_seg_parser_pkg.sv
// tcp_rx_seg_parser_pkg: shared constants and FSM state encoding for the TCP receive parser
package tcp_rx_seg_parser_pkg;
  localparam int TCP_HDR_BYTES = 20;
  localparam int TCP_MIN_DOFF = 5;
  localparam int FIN_BIT = 0;
  localparam int SYN_BIT = 1;
  localparam int RST_BIT = 2;
  localparam int PSH_BIT = 3;
  localparam int ACK_BIT = 4;
  typedef enum logic [2:0] {HDR, OPT, PAY, DROP, OUT} st_e;
endpackage

// File: rtl/tcp_rx_hdr_capture.sv
// tcp_rx_hdr_capture: shadow registers filled from the header byte stream by byte index
module tcp_rx_hdr_capture
  import tcp_rx_seg_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  idx,
  input  logic [7:0]  data,
  input  logic [15:0] listen_port,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] lport,
  output logic [31:0] seq,
  output logic [31:0] ack,
  output logic [3:0]  doff,
  output logic [4:0]  flags
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      src_port <= '0;
      dst_port <= '0;
      lport    <= '0;
      seq      <= '0;
      ack      <= '0;
      doff     <= '0;
      flags    <= '0;
    end else if (en) begin
      if (idx < 5'd2) src_port <= {src_port[7:0], data};
      else if (idx < 5'd4) dst_port <= {dst_port[7:0], data};
      else if (idx < 5'd8) seq <= {seq[23:0], data};
      else if (idx < 5'd12) ack <= {ack[23:0], data};
      else if (idx == 5'd12) doff <= data[7:4];
      else if (idx == 5'd13) flags <= data[ACK_BIT:FIN_BIT];
      if (idx == 5'd3) lport <= listen_port;
    end
endmodule

// File: rtl/tcp_rx_seg_parser.sv
// tcp_rx_seg_parser: parses TCP segment bytes, skips options, counts payload,
// filters on destination port and hands one decoded segment at a time downstream.
module tcp_rx_seg_parser
  import tcp_rx_seg_parser_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int DROP_W    = 16,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [15:0]       listen_port,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic [15:0]       seg_src_port,
  output logic [15:0]       seg_dst_port,
  output logic [31:0]       seg_seq,
  output logic [31:0]       seg_ack,
  output logic              seg_fin,
  output logic              seg_syn,
  output logic              seg_rst,
  output logic              seg_psh,
  output logic              seg_ack_flag,
  output logic [LEN_W-1:0]  seg_payload_len,
  output logic [DROP_W-1:0] drop_cnt
);
  st_e              state;
  logic [4:0]       idx;
  logic [5:0]       opt_rem;
  logic [LEN_W-1:0] len, len_inc, end_len;
  logic             acc, hdr_end, go_end, go_bad, deliver, drop;
  logic [15:0]      c_src, c_dst, c_lport;
  logic [31:0]      c_seq, c_ack;
  logic [3:0]       c_doff;
  logic [4:0]       c_flags;

  tcp_rx_hdr_capture u_cap (
    .clk         (clk),
    .rst         (rst),
    .en          (acc && state == HDR),
    .idx         (idx),
    .data        (in_data),
    .listen_port (listen_port),
    .src_port    (c_src),
    .dst_port    (c_dst),
    .lport       (c_lport),
    .seq         (c_seq),
    .ack         (c_ack),
    .doff        (c_doff),
    .flags       (c_flags)
  );

  // A segment ends well only at a complete header/option boundary or in payload;
  // every other in_last is a truncated or malformed segment.
  always_comb begin
    acc     = in_valid && in_ready;
    hdr_end = idx == 5'(TCP_HDR_BYTES - 1);
    len_inc = &len ? len : len + 1'b1;
    go_end  = acc && in_last && ((state == HDR && hdr_end && c_doff == 4'(TCP_MIN_DOFF)) ||
                                 (state == OPT && opt_rem == 6'd1) || state == PAY);
    go_bad  = acc && in_last && !go_end;
    deliver = go_end && (!FILTER_EN || c_dst == c_lport);
    drop    = go_bad || (go_end && !deliver);
    end_len = state == PAY ? len_inc : '0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= HDR;
      idx             <= '0;
      opt_rem         <= '0;
      len             <= '0;
      in_ready        <= 1'b1;
      seg_valid       <= 1'b0;
      seg_src_port    <= '0;
      seg_dst_port    <= '0;
      seg_seq         <= '0;
      seg_ack         <= '0;
      seg_fin         <= 1'b0;
      seg_syn         <= 1'b0;
      seg_rst         <= 1'b0;
      seg_psh         <= 1'b0;
      seg_ack_flag    <= 1'b0;
      seg_payload_len <= '0;
      drop_cnt        <= '0;
    end else if (drop) begin
      drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
      state    <= HDR;
      idx      <= '0;
    end else if (deliver) begin
      state           <= OUT;
      idx             <= '0;
      in_ready        <= 1'b0;
      seg_valid       <= 1'b1;
      seg_src_port    <= c_src;
      seg_dst_port    <= c_dst;
      seg_seq         <= c_seq;
      seg_ack         <= c_ack;
      seg_fin         <= c_flags[FIN_BIT];
      seg_syn         <= c_flags[SYN_BIT];
      seg_rst         <= c_flags[RST_BIT];
      seg_psh         <= c_flags[PSH_BIT];
      seg_ack_flag    <= c_flags[ACK_BIT];
      seg_payload_len <= end_len;
    end else begin
      case (state)
        HDR: if (acc) begin
          idx     <= hdr_end ? '0 : idx + 5'd1;
          opt_rem <= {c_doff, 2'b00} - 6'(TCP_HDR_BYTES);
          len     <= '0;
          if (hdr_end)
            state <= c_doff < 4'(TCP_MIN_DOFF) ? DROP : c_doff > 4'(TCP_MIN_DOFF) ? OPT : PAY;
        end
        OPT: if (acc) begin
          opt_rem <= opt_rem - 6'd1;
          if (opt_rem == 6'd1) state <= PAY;
        end
        PAY: if (acc) len <= len_inc;
        DROP: ;
        OUT: if (seg_ready) begin
          state     <= HDR;
          seg_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= HDR;
      endcase
    end
endmodule
